// File: rtl/dreg_serial_tx.sv
// Serial transmitter for the 4-bit D-register bank: small FIFO, then start/data MSB-first/even parity/stop framing.
// tx is registered from the next-state view so the line never glitches.
module dreg_serial_tx #(
    parameter int WIDTH     = 4,
    parameter int DIV       = 4,
    parameter int DEPTH     = 2,
    parameter int PARITY_EN = 1
) (
    input  logic                           clk,
    input  logic                           rest,
    input  logic [WIDTH-1:0]               din,
    input  logic                           din_valid,
    output logic                           din_ready,
    output logic                           tx,
    output logic                           busy,
    output logic                           frame_done,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]      wptr, rptr;
    logic [DW-1:0]      divcnt;
    logic [BW-1:0]      bitcnt;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic               par, par_n;
    logic               tx_n;
    logic               push, pop, nonempty, div_last, bit_last;

    assign nonempty  = (fifo_count != '0);
    assign din_ready = (fifo_count < CW'(DEPTH));
    assign push      = din_valid & din_ready;
    assign div_last  = (divcnt == DW'(DIV - 1));
    assign bit_last  = (bitcnt == BW'(WIDTH - 1));
    assign pop       = nonempty & ((state == IDLE) | ((state == STOP) & div_last));

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state <= IDLE;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            tx    <= tx_n;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        par_n   = par;
        case (state)
            IDLE:    if (nonempty) state_n = START;
            START:   if (div_last) state_n = DATA;
            DATA: begin
                if (div_last) begin
                    shreg_n = shreg << 1;
                    if (bit_last) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:  if (div_last) state_n = STOP;
            STOP:    if (div_last) state_n = nonempty ? START : IDLE;
            default: state_n = IDLE;
        endcase
        if (pop) begin
            shreg_n = mem[rptr];
            par_n   = ^mem[rptr];
        end
    end

    // Outputs
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[WIDTH-1];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        busy       = (state != IDLE);
        frame_done = (state == STOP) & div_last;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            divcnt <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
        end else begin
            divcnt <= ((state == IDLE) || div_last) ? '0 : divcnt + 1'b1;
            if (state == DATA && div_last) begin
                bitcnt <= bit_last ? '0 : bitcnt + 1'b1;
            end
            shreg <= shreg_n;
            par   <= par_n;
        end
    end

endmodule

// File: doc/dreg_serial_tx.md
Name: dreg_serial_tx

Overview:
- Transmit-side companion to the team's 4-bit D-register bank.
- Accepts parallel words from the register side over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word onto a single line as: start bit, data MSB-first (bit3..bit0, matching register bit order), optional even parity, stop bit.
- Sits between the register datapath and an external serial link or a matching receiver.

Parameters:
- WIDTH, 4, data word width in bits.
- DIV, 4, clock cycles per serial bit (≥1).
- DEPTH, 2, FIFO entries (≥1).
- PARITY_EN, 1, 1 = insert even parity bit after data; 0 = no parity bit.

Ports:
- clk  in  1  system clock, rising edge.
- rest  in  1  reset, asynchronous, active-high.
- din  in  WIDTH  parallel word to transmit.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line output, idle high.
- busy  out  1  frame in progress (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_count  out  clog2(DEPTH+1)  number of buffered words.

Behaviour:
- Reset (async, active-high): tx=1, busy=0, frame_done=0, fifo_count=0, FIFO pointers cleared, FSM=IDLE, bit/div counters=0.
  - din_ready=1 once rest deasserts.
  - Reset mid-frame aborts the frame: tx returns to 1 immediately and buffered words are discarded.
- Handshake:
  - din_ready = (fifo_count < DEPTH), combinational from count only.
  - Push occurs on a rising edge with din_valid & din_ready; din is captured on that edge.
  - din_valid while din_ready=0 is ignored; no data is lost from the FIFO.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Push and pop on the same edge: fifo_count unchanged, both pointers advance.
  - Pop only occurs on the FSM start transition and only when fifo_count > 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_count>0, pop head into shift register and go to START on the same edge.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: tx = shift_reg MSB, DIV cycles per bit, WIDTH bits, shifting left. After the last bit: PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the WIDTH data bits (even parity) for DIV cycles, then STOP.
  - STOP: tx=1 for DIV cycles; frame_done=1 on the final cycle only.
    - At the end of STOP, if fifo_count>0: pop and go directly to START, back-to-back with no idle gap.
    - Otherwise go to IDLE.
- Frame length: (2 + WIDTH + PARITY_EN) × DIV cycles; 28 cycles at defaults.
- Latency: push at edge E0 puts tx=0 from edge E1 when IDLE and FIFO was empty.
- A push during a frame does not disturb tx; the word is buffered.
- tx is driven from a register (glitch-free).
- busy is high from the START entry edge until the edge that returns to IDLE.

Test Plan:
- Reset, then push din=4'b1011 at E0.
  - tx low E1..E4 (start), then 1,0,1,1 each 4 cycles, parity=1 for 4 cycles, stop high 4 cycles.
  - frame_done high the single cycle before E29; busy falls at E29.
- Push 4'b0110, 4'b1111, 4'b0001 on consecutive cycles.
  - din_ready drops after the third push attempt: count 1→pop→…, so the third word is only accepted when count<2.
  - All three frames go out back-to-back, no idle gap between stop and start.
  - Parity bits are 0, 0, 1.
- FIFO full (count=2) with din_valid held high: no push occurs, count stays 2.
  - On the pop edge the held word is accepted next cycle and count returns to 2.
- Simultaneous push/pop at count=1 on a stop→start boundary: count stays 1; transmitted order is preserved.
- Assert rest mid-DATA of the word 4'b1010: tx=1, busy=0, and fifo_count=0 immediately.
  - After release, nothing is transmitted until a new push.
- PARITY_EN=0, DIV=1, push 4'b1001: tx = 0,1,0,0,1,1 over 6 cycles; frame_done in the 6th cycle.
